// File: rtl/tm_argmax_stream.sv
// Streaming argmax over LANES-wide beats of signed class sums.
// Emits winning index, sum, best-minus-second margin and tie flag per frame.
module tm_argmax_stream #(
    parameter int CLASS_NUM              = 10,
    parameter int WEIGHT_LENGTH          = 14,
    parameter int LANES                  = 2,
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    localparam int INDEX_LENGTH =
        (CLASS_NUM > 2) ? $clog2(CLASS_NUM) : 1,
    localparam int BEATS = (CLASS_NUM + LANES - 1) / LANES
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [LANES*WEIGHT_LENGTH-1:0]    s_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [INDEX_LENGTH-1:0]           m_index,
    output logic [WEIGHT_LENGTH-1:0]          m_max,
    output logic [WEIGHT_LENGTH:0]            m_margin,
    output logic                              m_tie,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] y
);

    localparam int W  = WEIGHT_LENGTH;
    localparam int IL = INDEX_LENGTH;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [BW-1:0]       beat_cnt;
    logic [BW-1:0]       beat_cnt_nxt;
    logic                accept;
    logic                last;

    logic signed [W-1:0] run_best;
    logic signed [W-1:0] run_sec;
    logic [IL-1:0]       run_idx;
    logic                run_sec_v;

    logic signed [W-1:0] lane;
    logic signed [W-1:0] bt_best;
    logic signed [W-1:0] bt_sec;
    logic [IL-1:0]       bt_idx;
    logic                bt_best_v;
    logic                bt_sec_v;

    logic signed [W-1:0] nx_best;
    logic signed [W-1:0] nx_sec;
    logic [IL-1:0]       nx_idx;
    logic                nx_sec_v;
    logic [W:0]          margin_nxt;

    assign s_ready = !(m_valid && !m_ready);
    assign accept  = s_valid && s_ready && !flush;
    assign last    = (beat_cnt == BW'(BEATS - 1));

    // Lanes scanned in ascending class order, so strict > keeps lowest index.
    always_comb begin
        lane      = '0;
        bt_best   = '0;
        bt_sec    = '0;
        bt_idx    = '0;
        bt_best_v = 1'b0;
        bt_sec_v  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (int'(beat_cnt) * LANES + k < CLASS_NUM) begin
                lane = s_data[k*W +: W];
                if (!bt_best_v || lane > bt_best) begin
                    bt_sec    = bt_best;
                    bt_sec_v  = bt_best_v;
                    bt_best   = lane;
                    bt_idx    = IL'(int'(beat_cnt) * LANES + k);
                    bt_best_v = 1'b1;
                end else if (!bt_sec_v || lane > bt_sec) begin
                    bt_sec   = lane;
                    bt_sec_v = 1'b1;
                end
            end
        end
    end

    // Running pair always precedes the beat in class order.
    always_comb begin
        nx_best  = bt_best;
        nx_idx   = bt_idx;
        nx_sec   = bt_sec;
        nx_sec_v = bt_sec_v;
        if (beat_cnt != '0) begin
            nx_best  = run_best;
            nx_idx   = run_idx;
            nx_sec   = run_sec;
            nx_sec_v = run_sec_v;
            if (bt_best > nx_best) begin
                nx_sec   = nx_best;
                nx_sec_v = 1'b1;
                nx_best  = bt_best;
                nx_idx   = bt_idx;
            end else if (!nx_sec_v || bt_best > nx_sec) begin
                nx_sec   = bt_best;
                nx_sec_v = 1'b1;
            end
            if (bt_sec_v && (!nx_sec_v || bt_sec > nx_sec)) begin
                nx_sec   = bt_sec;
                nx_sec_v = 1'b1;
            end
        end
    end

    assign margin_nxt = {nx_best[W-1], nx_best} - {nx_sec[W-1], nx_sec};

    always_comb begin
        beat_cnt_nxt = beat_cnt;
        if (flush) begin
            beat_cnt_nxt = '0;
        end else if (accept) begin
            beat_cnt_nxt = last ? '0 : beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            run_best  <= '0;
            run_sec   <= '0;
            run_idx   <= '0;
            run_sec_v <= 1'b0;
            m_valid   <= 1'b0;
            m_index   <= '0;
            m_max     <= '0;
            m_margin  <= '0;
            m_tie     <= 1'b0;
        end else begin
            beat_cnt <= beat_cnt_nxt;
            if (accept) begin
                run_best  <= nx_best;
                run_sec   <= nx_sec;
                run_idx   <= nx_idx;
                run_sec_v <= nx_sec_v;
            end
            if (accept && last) begin
                m_valid  <= 1'b1;
                m_index  <= nx_idx;
                m_max    <= nx_best;
                m_margin <= margin_nxt;
                m_tie    <= (margin_nxt == '0);
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign y = {{(C_M00_AXIS_TDATA_WIDTH-IL){1'b0}}, m_index};

endmodule
